// File: rtl/rv32im_alu_pkg.sv
// Shared op codes, FSM state type and op classification for the RV32IM sequential ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32im_alu_pkg;

    // Single-cycle RV32I ops
    localparam int unsigned OP_ADD    = 1;
    localparam int unsigned OP_SUB    = 2;
    localparam int unsigned OP_SLT    = 3;
    localparam int unsigned OP_SLTU   = 4;
    localparam int unsigned OP_BEQ    = 5;
    localparam int unsigned OP_BNE    = 6;
    localparam int unsigned OP_BLT    = 7;
    localparam int unsigned OP_BGE    = 8;
    localparam int unsigned OP_BLTU   = 9;
    localparam int unsigned OP_BGEU   = 10;
    localparam int unsigned OP_AND    = 11;
    localparam int unsigned OP_OR     = 12;
    localparam int unsigned OP_XOR    = 13;
    localparam int unsigned OP_SLL    = 14;
    localparam int unsigned OP_SRL    = 15;
    localparam int unsigned OP_SRA    = 16;

    // Iterative M-extension ops
    localparam int unsigned OP_MUL    = 17;
    localparam int unsigned OP_MULH   = 18;
    localparam int unsigned OP_MULHSU = 19;
    localparam int unsigned OP_MULHU  = 20;
    localparam int unsigned OP_DIV    = 21;
    localparam int unsigned OP_DIVU   = 22;
    localparam int unsigned OP_REM    = 23;
    localparam int unsigned OP_REMU   = 24;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // True for ops that go through the multi-cycle mul/div engine
    function automatic logic is_muldiv(input int unsigned code);
        return (code >= OP_MUL) && (code <= OP_REMU);
    endfunction

endpackage

// File: rtl/rv32im_muldiv_iter.sv
// Radix-2 shift-add multiplier and restoring divider on sign-magnitude operands.
// Latency: WIDTH cycles of iteration after start; done is high during the last one.
// Backpressure: none; result holds in registers until the next start, abort drops busy.
module rv32im_muldiv_iter
    import rv32im_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      op_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    logic [WIDTH-1:0] acc;    // product high half / partial remainder
    logic [WIDTH-1:0] lo;     // multiplier bits / dividend bits becoming quotient
    logic [WIDTH-1:0] opnd;   // multiplicand / divisor magnitude
    logic [WIDTH-1:0] a_q;    // raw dividend, returned as remainder on divide by zero
    logic [WIDTH-1:0] count;
    logic             is_mul_q;
    logic             want_hi_q;
    logic             want_rem_q;
    logic             neg_q;
    logic             div0_q;

    logic [WIDTH-1:0] ld_lo;
    logic [WIDTH-1:0] ld_opnd;
    logic             ld_neg;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // Operand preparation: strip signs so the datapath only handles magnitudes
    always_comb begin
        ld_lo   = b;
        ld_opnd = a;
        ld_neg  = 1'b0;
        case (op_code)
            OP_MULH: begin
                ld_lo   = mag(b);
                ld_opnd = mag(a);
                ld_neg  = a[WIDTH-1] ^ b[WIDTH-1];
            end
            OP_MULHSU: begin
                ld_opnd = mag(a);
                ld_neg  = a[WIDTH-1];
            end
            OP_DIV: begin
                ld_lo   = mag(a);
                ld_opnd = mag(b);
                ld_neg  = a[WIDTH-1] ^ b[WIDTH-1];
            end
            OP_DIVU, OP_REMU: begin
                ld_lo   = a;
                ld_opnd = b;
            end
            OP_REM: begin
                ld_lo   = mag(a);
                ld_opnd = mag(b);
                ld_neg  = a[WIDTH-1];
            end
            default: ;
        endcase
    end

    // One iteration step for each engine
    always_comb begin
        mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
        rem_sh  = {acc, lo[WIDTH-1]};
        rem_ge  = rem_sh >= {1'b0, opnd};
        rem_sub = rem_sh[WIDTH-1:0] - opnd;
    end

    // Sign fix-up and special-case selection of the final result
    always_comb begin
        prod_s = neg_q ? -{acc, lo} : {acc, lo};
        quo_s  = neg_q ? -lo : lo;
        rem_s  = neg_q ? -acc : acc;
        if (is_mul_q)
            result = want_hi_q ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
        else if (div0_q)
            result = want_rem_q ? a_q : '1;
        else
            result = want_rem_q ? rem_s : quo_s;
    end

    assign done = busy && (count == LAST);

    // Load on start, iterate while busy, stop after WIDTH steps or on abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            lo         <= '0;
            opnd       <= '0;
            a_q        <= '0;
            count      <= '0;
            busy       <= 1'b0;
            is_mul_q   <= 1'b0;
            want_hi_q  <= 1'b0;
            want_rem_q <= 1'b0;
            neg_q      <= 1'b0;
            div0_q     <= 1'b0;
        end else if (abort) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            acc        <= '0;
            lo         <= ld_lo;
            opnd       <= ld_opnd;
            a_q        <= a;
            count      <= '0;
            busy       <= 1'b1;
            is_mul_q   <= (op_code >= OP_MUL) && (op_code <= OP_MULHU);
            want_hi_q  <= (op_code != OP_MUL);
            want_rem_q <= (op_code == OP_REM) || (op_code == OP_REMU);
            neg_q      <= ld_neg;
            div0_q     <= (b == '0);
        end else if (busy) begin
            if (is_mul_q) begin
                acc <= mul_sum[WIDTH:1];
                lo  <= {mul_sum[0], lo[WIDTH-1:1]};
            end else begin
                acc <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                lo  <= {lo[WIDTH-2:0], rem_ge};
            end
            count <= count + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/rv32im_seq_alu.sv
// RV32I ALU plus iterative RV32M mul/div behind a valid/ready handshake, one op in flight.
// Latency: 1 cycle for base and illegal ops, WIDTH+1 cycles for mul/div ops.
// Backpressure: result held in DONE until out_ready; no new op accepted until back in IDLE.
module rv32im_seq_alu
    import rv32im_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             taken,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      op_i;
    logic             accept;
    logic             op_md;
    logic [SHW-1:0]   sh;
    logic             lt_s;
    logic             lt_u;

    logic [WIDTH-1:0] sc_res;
    logic             sc_taken;
    logic             sc_illegal;

    logic [WIDTH-1:0] res_q;
    logic             taken_q;
    logic             illegal_q;
    logic             md_sel_q;

    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_res;

    assign op_i      = 32'(op);
    assign op_md     = is_muldiv(op_i);
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready && !kill;
    assign sh        = b[SHW-1:0];
    assign lt_s      = $signed(a) < $signed(b);
    assign lt_u      = a < b;

    rv32im_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && op_md),
        .abort   (kill),
        .op_code (op_i),
        .a       (a),
        .b       (b),
        .busy    (md_busy),
        .done    (md_done),
        .result  (md_res)
    );

    // Single-cycle datapath, evaluated straight off the inputs at acceptance
    always_comb begin
        sc_res     = '0;
        sc_taken   = 1'b0;
        sc_illegal = 1'b0;
        case (op_i)
            OP_ADD:  sc_res = a + b;
            OP_SUB:  sc_res = a - b;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, lt_u};
            OP_BEQ:  sc_taken = (a == b);
            OP_BNE:  sc_taken = (a != b);
            OP_BLT:  sc_taken = lt_s;
            OP_BGE:  sc_taken = !lt_s;
            OP_BLTU: sc_taken = lt_u;
            OP_BGEU: sc_taken = !lt_u;
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_SLL:  sc_res = a << sh;
            OP_SRL:  sc_res = a >> sh;
            OP_SRA:  sc_res = $signed(a) >>> sh;
            default: sc_illegal = !op_md;
        endcase
    end

    // Next-state logic; kill overrides acceptance and the output handshake
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = op_md ? S_CALC : S_DONE;
            S_CALC: if (md_done) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (kill)
            state_nxt = S_IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Result capture at acceptance; mul/div results are read from the engine instead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q     <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            md_sel_q  <= 1'b0;
        end else if (accept) begin
            res_q     <= op_md ? '0 : sc_res;
            taken_q   <= op_md ? 1'b0 : sc_taken;
            illegal_q <= op_md ? 1'b0 : sc_illegal;
            md_sel_q  <= op_md;
        end
    end

    assign res     = md_sel_q ? md_res : res_q;
    assign taken   = taken_q;
    assign illegal = illegal_q;

endmodule
